// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit.
// Contents:
//   - default width and latency values (operand width, mult and div busy cycles)
//   - MDUCtrl operation codes (4 bit)
//   - FSM state encoding (IDLE / RUN)
//   - is_arith_op(): true for the opcodes that start a multi-cycle operation
package mdu_pkg;

  localparam int DEF_WIDTH       = 32;
  localparam int DEF_MULT_CYCLES = 5;
  localparam int DEF_DIV_CYCLES  = 10;

  localparam logic [3:0] OP_NONE  = 4'd0;
  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
  localparam logic [3:0] OP_MFHI  = 4'd7;
  localparam logic [3:0] OP_MFLO  = 4'd8;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } mdu_state_e;

  // Only mult/multu/div/divu occupy the unit for several cycles.
  function automatic logic is_arith_op(input logic [3:0] op);
    return (op >= OP_MULT) && (op <= OP_DIVU);
  endfunction

endpackage

// File: rtl/mult_div_unit_if.sv
// Bus between the E stage and the multiply/divide unit.
// Signals:
//   srca       rs operand (dividend / multiplicand / mthi-mtlo data)
//   srcb       rt operand (divisor / multiplier)
//   mductrl    operation code (see mdu_pkg)
//   start      one-cycle pulse qualifying mult/multu/div/divu
//   busy       operation in flight (registered in the unit)
//   mduresult  HI when mductrl selects mfhi, LO otherwise
// Modports:
//   master  pipeline side (drives operands, opcode, start)
//   slave   unit side (drives busy, mduresult)
interface mult_div_unit_if #(
  parameter int WIDTH = 32
);

  logic [WIDTH-1:0] srca;
  logic [WIDTH-1:0] srcb;
  logic [3:0]       mductrl;
  logic             start;
  logic             busy;
  logic [WIDTH-1:0] mduresult;

  modport master (
    output srca,
    output srcb,
    output mductrl,
    output start,
    input  busy,
    input  mduresult
  );

  modport slave (
    input  srca,
    input  srcb,
    input  mductrl,
    input  start,
    output busy,
    output mduresult
  );

endinterface

// File: rtl/mult_div_unit.sv
// Multi-cycle multiply/divide unit with HI/LO registers.
// The result of mult/multu/div/divu is computed at the launch edge into pending
// registers; the unit then stays busy for MULT_CYCLES or DIV_CYCLES cycles and
// commits the pending value to HI/LO on the edge that ends the last busy cycle.
// mthi/mtlo write HI/LO directly when the unit is idle and no start is present.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   mdu    slave side of mult_div_unit_if (operands, opcode, start, busy, result)
module mult_div_unit
  import mdu_pkg::*;
#(
  parameter int WIDTH       = DEF_WIDTH,
  parameter int MULT_CYCLES = DEF_MULT_CYCLES,
  parameter int DIV_CYCLES  = DEF_DIV_CYCLES
) (
  input  logic           clk,
  input  logic           rst_n,
  mult_div_unit_if.slave mdu
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES + 1);

  localparam logic [CW-1:0]    MULT_LOAD = CW'(MULT_CYCLES);
  localparam logic [CW-1:0]    DIV_LOAD  = CW'(DIV_CYCLES);
  localparam logic [CW-1:0]    CNT_ONE   = CW'(1);
  localparam logic [WIDTH-1:0] ONE       = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] MOST_NEG  = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] ALL_ONES  = '1;

  // ---------------------------------------------------------------------------
  // Bus inputs
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [3:0]       op;

  assign op_a = mdu.srca;
  assign op_b = mdu.srcb;
  assign op   = mdu.mductrl;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  mdu_state_e       state_reg, state_next;
  logic [CW-1:0]    count_reg, count_next;
  logic             busy_reg, busy_next;
  logic [WIDTH-1:0] hi_reg, lo_reg;
  logic [WIDTH-1:0] pend_hi_reg, pend_lo_reg;
  logic             pend_we_reg;

  logic launch;
  logic last_cycle;
  logic commit;
  logic mthi_we;
  logic mtlo_we;

  // ---------------------------------------------------------------------------
  // Arithmetic on the operands present at the launch edge
  // ---------------------------------------------------------------------------
  logic [2*WIDTH-1:0]        a_zx, b_zx, prod_u;
  logic signed [2*WIDTH-1:0] a_sx, b_sx, prod_s;
  logic                      div_zero;
  logic                      div_ovf;
  logic [WIDTH-1:0]          safe_div;
  logic signed [WIDTH-1:0]   a_s, d_s, quo_s, rem_s;
  logic [WIDTH-1:0]          quo_u, rem_u;

  logic [WIDTH-1:0] res_hi;
  logic [WIDTH-1:0] res_lo;
  logic             res_we;

  // Operands are widened explicitly so the products are full 2*WIDTH results.
  assign a_zx   = {{WIDTH{1'b0}}, op_a};
  assign b_zx   = {{WIDTH{1'b0}}, op_b};
  assign a_sx   = {{WIDTH{op_a[WIDTH-1]}}, op_a};
  assign b_sx   = {{WIDTH{op_b[WIDTH-1]}}, op_b};
  assign prod_u = a_zx * b_zx;
  assign prod_s = a_sx * b_sx;

  // The divider never sees a zero divisor, nor the one signed pair whose
  // quotient overflows. MOST_NEG / -1 is replaced by MOST_NEG / 1, which
  // produces exactly the required LO=MOST_NEG, HI=0. A zero divisor is
  // replaced by 1 and the result is discarded through res_we.
  assign div_zero = (op_b == '0);
  assign div_ovf  = (op_a == MOST_NEG) && (op_b == ALL_ONES);
  assign safe_div = (div_zero || div_ovf) ? ONE : op_b;

  assign a_s   = op_a;
  assign d_s   = safe_div;
  assign quo_s = a_s / d_s;   // truncates toward zero
  assign rem_s = a_s % d_s;   // takes the sign of the dividend
  assign quo_u = op_a / safe_div;
  assign rem_u = op_a % safe_div;

  always_comb begin
    res_hi = '0;
    res_lo = '0;
    res_we = 1'b0;
    case (op)
      OP_MULT: begin
        {res_hi, res_lo} = prod_s;
        res_we           = 1'b1;
      end
      OP_MULTU: begin
        {res_hi, res_lo} = prod_u;
        res_we           = 1'b1;
      end
      OP_DIV: begin
        res_hi = rem_s;
        res_lo = quo_s;
        res_we = !div_zero;
      end
      OP_DIVU: begin
        res_hi = rem_u;
        res_lo = quo_u;
        res_we = !div_zero;
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
      count_reg <= '0;
      busy_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      count_reg <= count_next;
      busy_reg  <= busy_next;
    end
  end

  // A start is honoured only from IDLE and only for the four arithmetic ops.
  assign launch = (state_reg == ST_IDLE) && mdu.start && is_arith_op(op);

  // <= rather than == so a zero count can never strand the FSM in RUN.
  assign last_cycle = (state_reg == ST_RUN) && (count_reg <= CNT_ONE);

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: if (launch)     state_next = ST_RUN;
      ST_RUN:  if (last_cycle) state_next = ST_IDLE;
      default:                 state_next = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    busy_next  = (state_next == ST_RUN);
    commit     = last_cycle && pend_we_reg;
    mthi_we    = (state_reg == ST_IDLE) && !mdu.start && (op == OP_MTHI);
    mtlo_we    = (state_reg == ST_IDLE) && !mdu.start && (op == OP_MTLO);
    count_next = count_reg;
    if (launch) begin
      count_next = ((op == OP_MULT) || (op == OP_MULTU)) ? MULT_LOAD : DIV_LOAD;
    end else if ((state_reg == ST_RUN) && (count_reg != '0)) begin
      count_next = count_reg - CNT_ONE;
    end
  end

  // ---------------------------------------------------------------------------
  // Pending result, loaded once at launch and held through RUN
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_hi_reg <= '0;
      pend_lo_reg <= '0;
      pend_we_reg <= 1'b0;
    end else if (launch) begin
      pend_hi_reg <= res_hi;
      pend_lo_reg <= res_lo;
      pend_we_reg <= res_we;
    end
  end

  // ---------------------------------------------------------------------------
  // HI/LO. commit only happens in RUN and mthi/mtlo only in IDLE, so the two
  // write sources never collide.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_reg <= '0;
      lo_reg <= '0;
    end else if (commit) begin
      hi_reg <= pend_hi_reg;
      lo_reg <= pend_lo_reg;
    end else begin
      if (mthi_we) hi_reg <= op_a;
      if (mtlo_we) lo_reg <= op_a;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign mdu.busy      = busy_reg;
  assign mdu.mduresult = (op == OP_MFHI) ? hi_reg : lo_reg;

endmodule
